popcount_sched: RTL and testbench



---
 rtl/popcount_sched.sv | 120 ++++++++++++
 tb/tb_popcount_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/popcount_sched.sv
// Round-robin sequencer that streams multi-byte operands through one shared
// combinational 8-bit one-counter and returns the accumulated total per requester.
module popcount_sched #(
    parameter int NREQ = 4,
    parameter int NBYTES = 4,
    localparam int OPW = 8 * NBYTES,
    localparam int CW = $clog2(OPW + 1),
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*OPW-1:0]   req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            cu_a,
    input  logic [3:0]            cu_count,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CW-1:0]         res_count,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    localparam int IXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [OPW-1:0]   op;
    logic [IDW-1:0]   id;
    logic [CW-1:0]    acc;
    logic [IXW-1:0]   idx;
    logic [IDW-1:0]   rr_ptr;
    logic             gnt_hit;
    logic [IDW-1:0]   gnt_id;
    logic             accept;
    logic             last_byte;

    // First valid requester strictly after the last served one, wrapping around.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_id  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!gnt_hit && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                gnt_hit = 1'b1;
                gnt_id  = IDW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign accept    = (state == IDLE) && gnt_hit && !rst;
    assign last_byte = (idx == IXW'(NBYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready and cu_a are gated by rst so an aborted or reset cycle never leaks a strobe.
    always_comb begin
        req_ready = '0;
        cu_a      = 8'h00;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
        if (state == RUN && !rst) begin
            cu_a = op[int'(idx) * 8 +: 8];
        end
        res_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    assign res_count = acc;
    assign res_id    = id;

    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            id     <= '0;
            acc    <= '0;
            idx    <= '0;
            rr_ptr <= IDW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op  <= req_data[int'(gnt_id) * OPW +: OPW];
                        id  <= gnt_id;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + CW'(cu_count);
                    idx <= idx + IXW'(1);
                end
                DONE: begin
                    if (res_ready) begin
                        rr_ptr <= id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched with a behavioural one-counter on the cu_* ports.
module tb_popcount_sched;

    localparam int NREQ = 4;
    localparam int NBYTES = 4;
    localparam int OPW = 32;
    localparam int CW = 6;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*OPW-1:0]  req_data;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           cu_a;
    logic [3:0]           cu_count;
    logic                 res_valid;
    logic                 res_ready;
    logic [CW-1:0]        res_count;
    logic [IDW-1:0]       res_id;
    logic                 busy;

    logic [31:0] opnd [NREQ];
    int n_chk = 0;
    int n_bad = 0;
    time t_acc;
    time t_prev;

    always #5 clk = ~clk;

    assign req_data = {opnd[3], opnd[2], opnd[1], opnd[0]};
    assign cu_count = 4'($countones(cu_a));

    popcount_sched #(.NREQ(NREQ), .NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cu_a(cu_a), .cu_count(cu_count),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_id(res_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle just after the edge; ends in the first IDLE cycle after the result.
    task automatic xact(input string tag, input logic [3:0] vld, input int g,
                        input bit keep, input int exp_cnt);
        logic [31:0] w;
        logic [7:0]  b;
        req_valid = vld;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready), 32'(4'b0001 << g));
        chk({tag, "_idle_rv"}, 32'(res_valid), 32'd0);
        t_acc = $time;
        tick();
        if (!keep) req_valid = vld & ~(4'b0001 << g);
        w = opnd[g];
        for (int k = 0; k < NBYTES; k++) begin
            @(negedge clk);
            b = w[k*8 +: 8];
            chk({tag, "_cu_a"}, 32'(cu_a), 32'(b));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_rdy_run"}, 32'(req_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk({tag, "_rv"}, 32'(res_valid), 32'd1);
        chk({tag, "_cnt"}, 32'(res_count), 32'(exp_cnt));
        chk({tag, "_id"}, 32'(res_id), 32'(g));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) opnd[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rv", 32'(res_valid), 32'd0);
        chk("rst_cnt", 32'(res_count), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cu_a", 32'(cu_a), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        tick();

        // single requester, all ones
        opnd[0] = 32'hFFFF_FFFF;
        res_ready = 1'b1;
        xact("ones", 4'b0001, 0, 1'b0, 32);

        // mixed data and all zeros
        opnd[2] = 32'h0F0F_0F01;
        xact("mixed", 4'b0100, 2, 1'b0, 13);
        opnd[3] = 32'h0000_0000;
        xact("zeros", 4'b1000, 3, 1'b0, 0);

        // round robin with everyone requesting
        opnd[1] = 32'h8000_0001;
        xact("rr0", 4'b1111, 0, 1'b1, 32);
        t_prev = t_acc;
        xact("rr1", 4'b1111, 1, 1'b1, 2);
        chk("rr_gap1", 32'(t_acc - t_prev), 32'd60);
        t_prev = t_acc;
        xact("rr2", 4'b1111, 2, 1'b1, 13);
        chk("rr_gap2", 32'(t_acc - t_prev), 32'd60);
        t_prev = t_acc;
        xact("rr3", 4'b1111, 3, 1'b1, 0);
        chk("rr_gap3", 32'(t_acc - t_prev), 32'd60);
        xact("rr4", 4'b1111, 0, 1'b1, 32);
        xact("rr5", 4'b1111, 1, 1'b0, 2);

        // result backpressure while requester 0 waits
        opnd[2] = 32'h00FF_00FF;
        res_ready = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("bp_rdy", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        repeat (NBYTES) tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rv", 32'(res_valid), 32'd1);
            chk("bp_cnt", 32'(res_count), 32'd16);
            chk("bp_id", 32'(res_id), 32'd2);
            chk("bp_rdy_hold", 32'(req_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_rv_last", 32'(res_valid), 32'd1);
        tick();
        xact("bp_next", 4'b0001, 0, 1'b0, 32);

        // reset in the middle of RUN
        opnd[1] = 32'hFFFF_FFFF;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("mr_rdy", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_cu_a_rst", 32'(cu_a), 32'd0);
        chk("mr_rdy_rst", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_rv", 32'(res_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cnt", 32'(res_count), 32'd0);
        chk("mr_id", 32'(res_id), 32'd0);
        chk("mr_cu_a", 32'(cu_a), 32'd0);
        chk("mr_rdy0", 32'(req_ready), 32'd0);
        tick();
        xact("mr_next", 4'b0011, 0, 1'b0, 32);

        // withdrawn request: requester 1 would win if it stayed valid
        req_valid = 4'b0000;
        res_ready = 1'b0;
        opnd[3] = 32'h1234_5678;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("wd_rdy0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b1000;
        repeat (NBYTES) tick();
        req_valid = 4'b1010;
        @(negedge clk);
        chk("wd_done_rv", 32'(res_valid), 32'd1);
        chk("wd_done_rdy", 32'(req_ready), 32'd0);
        tick();
        res_ready = 1'b1;
        req_valid = 4'b1000;
        @(negedge clk);
        chk("wd_done_rdy2", 32'(req_ready), 32'd0);
        tick();
        xact("wd", 4'b1000, 3, 1'b0, 13);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
